bram_result_streamer: RTL and testbench

BRAM_RESULT_STREAMER -- requirements
Module: bram_result_streamer

---
 rtl/softmax_pkg.sv | 16 +
 rtl/bram_row_serializer.sv | 68 ++++++
 rtl/bram_result_streamer.sv | 108 ++++++++++
 tb/tb_bram_result_streamer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// Shared constants and state type for the softmax result streamer.
package softmax_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ROW_W  = 1024;
    localparam int DEF_MODE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } stream_state_e;

endpackage

// File: rtl/bram_row_serializer.sv
// Holds one BRAM row and emits it word by word over a valid/ready stream.
module bram_row_serializer
    import softmax_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ROW_W  = DEF_ROW_W,
    parameter int MODE_W = DEF_MODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [ROW_W-1:0]  row_data,
    input  logic [MODE_W-1:0] row_mode_in,
    input  logic              last_row,
    input  logic              tready,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    output logic [MODE_W-1:0] row_mode,
    output logic              row_done
);

    localparam int WORDS = ROW_W / DATA_W;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [ROW_W-1:0]  row_q;
    logic [WC_W-1:0]   wcnt_q;
    logic              valid_q;
    logic [MODE_W-1:0] mode_q;
    logic              fire;
    logic              last_word;

    assign fire      = en & valid_q & tready;
    assign last_word = (wcnt_q == WC_W'(WORDS - 1));

    // The row is shifted down so the current word always sits at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            mode_q  <= '0;
        end else if (en) begin
            if (load) begin
                row_q   <= row_data;
                wcnt_q  <= '0;
                valid_q <= 1'b1;
                mode_q  <= row_mode_in;
            end else if (fire) begin
                row_q <= row_q >> DATA_W;
                if (last_word) begin
                    wcnt_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    wcnt_q <= wcnt_q + WC_W'(1);
                end
            end
        end
    end

    assign tdata    = row_q[DATA_W-1:0];
    assign tvalid   = valid_q;
    assign tlast    = valid_q & last_word & last_row;
    assign row_mode = mode_q;
    assign row_done = fire & last_word;

endmodule

// File: rtl/bram_result_streamer.sv
// Reads rows 0..depth from a BRAM port and streams each row as DATA_W words.
module bram_result_streamer
    import softmax_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ROW_W    = DEF_ROW_W,
    parameter int MODE_W   = DEF_MODE_W,
    parameter int READ_LAT = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [7:0]              i_depth,
    input  logic                    i_start,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_cenb,
    output logic [7:0]              o_addrb,
    input  logic [ROW_W+MODE_W-1:0] i_doutb,
    output logic [DATA_W-1:0]       o_tdata,
    output logic                    o_tvalid,
    input  logic                    i_tready,
    output logic                    o_tlast,
    output logic [MODE_W-1:0]       o_row_mode
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

    stream_state_e state_q;
    stream_state_e state_d;
    logic [7:0]    row_q;
    logic [7:0]    depth_q;
    logic [1:0]    lat_q;
    logic          last_row;
    logic          load;
    logic          row_done;

    assign last_row = (row_q == depth_q);
    assign load     = i_en & (state_q == ST_WAIT) & (lat_q == LAT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else if (i_en) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_READ;
            ST_READ:  state_d = ST_WAIT;
            ST_WAIT:  if (lat_q == LAT_LAST) state_d = ST_SHIFT;
            ST_SHIFT: if (row_done) state_d = last_row ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Depth is latched at start so the host may change it mid-stream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q   <= '0;
            depth_q <= '0;
            lat_q   <= '0;
        end else if (i_en) begin
            if (state_q == ST_IDLE && i_start) begin
                row_q   <= '0;
                depth_q <= i_depth;
            end
            if (state_q == ST_READ) begin
                lat_q <= '0;
            end else if (state_q == ST_WAIT) begin
                lat_q <= lat_q + 2'd1;
            end
            if (state_q == ST_SHIFT && row_done && !last_row) begin
                row_q <= row_q + 8'd1;
            end
        end
    end

    assign o_busy  = (state_q != ST_IDLE);
    assign o_done  = (state_q == ST_DONE);
    assign o_cenb  = (state_q == ST_READ);
    assign o_addrb = row_q;

    bram_row_serializer #(
        .DATA_W (DATA_W),
        .ROW_W  (ROW_W),
        .MODE_W (MODE_W)
    ) u_ser (
        .clk         (i_clk),
        .rst_n       (i_rst_n),
        .en          (i_en),
        .load        (load),
        .row_data    (i_doutb[ROW_W-1:0]),
        .row_mode_in (i_doutb[ROW_W+MODE_W-1:ROW_W]),
        .last_row    (last_row),
        .tready      (i_tready),
        .tdata       (o_tdata),
        .tvalid      (o_tvalid),
        .tlast       (o_tlast),
        .row_mode    (o_row_mode),
        .row_done    (row_done)
    );

endmodule

// File: tb/tb_bram_result_streamer.sv
// Directed bench for bram_result_streamer with a 1-cycle BRAM model.
module tb_bram_result_streamer;

    localparam int DATA_W = 32;
    localparam int ROW_W  = 1024;
    localparam int MODE_W = 4;
    localparam int WORDS  = ROW_W / DATA_W;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [7:0]              depth;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    cenb;
    logic [7:0]              addrb;
    logic [ROW_W+MODE_W-1:0] doutb;
    logic [DATA_W-1:0]       tdata;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;
    logic [MODE_W-1:0]       row_mode;

    int checks = 0;
    int errors = 0;

    bram_result_streamer #(
        .DATA_W   (DATA_W),
        .ROW_W    (ROW_W),
        .MODE_W   (MODE_W),
        .READ_LAT (1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_depth    (depth),
        .i_start    (start),
        .o_busy     (busy),
        .o_done     (done),
        .o_cenb     (cenb),
        .o_addrb    (addrb),
        .i_doutb    (doutb),
        .o_tdata    (tdata),
        .o_tvalid   (tvalid),
        .i_tready   (tready),
        .o_tlast    (tlast),
        .o_row_mode (row_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // BRAM model: word w of row r holds (r<<8)|w, mode field is mode_val.
    logic [MODE_W-1:0] mode_val = '0;
    logic [7:0]        rd_addr = '0;

    function automatic logic [ROW_W+MODE_W-1:0] build_row(
        input logic [7:0] r, input logic [MODE_W-1:0] m);
        logic [ROW_W+MODE_W-1:0] v;
        v = '0;
        for (int w = 0; w < WORDS; w++)
            v[w*DATA_W +: DATA_W] = (32'(r) << 8) | 32'(w);
        v[ROW_W +: MODE_W] = m;
        return v;
    endfunction

    always @(posedge clk) if (cenb && en) rd_addr <= addrb;
    always_comb doutb = build_row(rd_addr, mode_val);

    // Stream monitor: sampled on the falling edge, ahead of the accepting edge.
    int          exp_idx, n_words, n_bad, n_tlast, n_done;
    int          n_stall, n_stall_bad, last_cyc, done_cyc;
    int          depth_exp;
    logic [7:0]  max_addr;
    bit          stall_pend;
    logic [DATA_W-1:0] held_data;
    logic        held_last;

    task automatic mon_clear();
        exp_idx = 0; n_words = 0; n_bad = 0; n_tlast = 0; n_done = 0;
        n_stall = 0; n_stall_bad = 0; last_cyc = -1; done_cyc = -1;
        max_addr = '0; stall_pend = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cenb && addrb > max_addr) max_addr = addrb;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (en && stall_pend) begin
                if (tdata !== held_data || tlast !== held_last || tvalid !== 1'b1)
                    n_stall_bad++;
            end
            if (en) begin
                stall_pend = tvalid && !tready;
                if (stall_pend) n_stall++;
                held_data = tdata;
                held_last = tlast;
            end
            if (en && tvalid && tready) begin
                int r;
                int w;
                r = exp_idx / WORDS;
                w = exp_idx % WORDS;
                if (tdata !== DATA_W'((r << 8) | w)) n_bad++;
                if (tlast !== ((r == depth_exp) && (w == WORDS - 1))) n_bad++;
                if (row_mode !== mode_val) n_bad++;
                if (tlast) begin
                    n_tlast++;
                    last_cyc = cyc;
                end
                exp_idx++;
                n_words++;
            end
        end
    end

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, output bit got);
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (toggle) tready = ~tready;
            if (n_done > 0) begin
                got = 1;
                break;
            end
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (busy !== 0 || done !== 0 || cenb !== 0 || addrb !== 0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b cenb=%b addrb=%h, want all 0",
                     busy, done, cenb, addrb);
        end
        checks++;
        if (tvalid !== 0 || tlast !== 0 || tdata !== 0 || row_mode !== 0) begin
            errors++;
            $display("FAIL reset_stream: tvalid=%b tlast=%b tdata=%h mode=%h, want all 0",
                     tvalid, tlast, tdata, row_mode);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single_row();
        bit got;
        mon_clear(); depth_exp = 0; mode_val = 4'h5; depth = 8'd0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (cenb !== 1'b1 || addrb !== 8'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_cycle: cenb=%b addrb=%h busy=%b, want 1 00 1", cenb, addrb, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (cenb !== 1'b0 || tvalid !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle: cenb=%b tvalid=%b, want 0 0", cenb, tvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (tvalid !== 1'b1 || tdata !== 32'd0 || row_mode !== 4'h5) begin
            errors++;
            $display("FAIL first_word: tvalid=%b tdata=%h mode=%h, want 1 0 5",
                     tvalid, tdata, row_mode);
        end
        wait_done(200, 0, got);
        checks++;
        if (got !== 1'b1 || n_words !== 32 || n_bad !== 0 || n_tlast !== 1) begin
            errors++;
            $display("FAIL single_row: done=%b words=%0d bad=%0d tlast=%0d, want 1 32 0 1",
                     got, n_words, n_bad, n_tlast);
        end
        checks++;
        if (done_cyc !== last_cyc + 1) begin
            errors++;
            $display("FAIL done_timing: done_cyc=%0d, want %0d", done_cyc, last_cyc + 1);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL after_done: busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_back_to_back_stall();
        bit got;
        mon_clear(); depth_exp = 2; mode_val = 4'h3; depth = 8'd2;
        do_start();
        wait_done(1000, 1, got);
        checks++;
        if (got !== 1'b1 || n_words !== 96 || n_bad !== 0 || n_tlast !== 1) begin
            errors++;
            $display("FAIL stall_stream: done=%b words=%0d bad=%0d tlast=%0d, want 1 96 0 1",
                     got, n_words, n_bad, n_tlast);
        end
        checks++;
        if (n_stall < 1 || n_stall_bad !== 0) begin
            errors++;
            $display("FAIL stall_hold: stalls=%0d unstable=%0d, want >0 0", n_stall, n_stall_bad);
        end
    endtask

    task automatic test_start_ignored();
        bit got;
        int i;
        mon_clear(); depth_exp = 1; mode_val = 4'hC; depth = 8'd1;
        do_start();
        for (i = 0; i < 20 && tvalid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b1; depth = 8'd7;
        @(posedge clk); #1 start = 1'b0;
        wait_done(500, 0, got);
        checks++;
        if (got !== 1'b1 || n_words !== 64 || n_bad !== 0 || n_tlast !== 1 || max_addr !== 8'd1) begin
            errors++;
            $display("FAIL start_ignored: done=%b words=%0d bad=%0d tlast=%0d maxaddr=%0d, want 1 64 0 1 1",
                     got, n_words, n_bad, n_tlast, max_addr);
        end
        depth = 8'd0;
    endtask

    task automatic test_reset_mid();
        bit got;
        int i;
        mon_clear(); depth_exp = 2; mode_val = 4'h9; depth = 8'd2;
        do_start();
        for (i = 0; i < 300 && exp_idx != 42; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (tdata !== 32'h0000_010a || tvalid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: tdata=%h tvalid=%b, want 0000010a 1", tdata, tvalid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tvalid !== 0 || tdata !== 0 || tlast !== 0 || row_mode !== 0 ||
            busy !== 0 || done !== 0 || cenb !== 0 || addrb !== 0) begin
            errors++;
            $display("FAIL mid_reset: tv=%b td=%h tl=%b md=%h bz=%b dn=%b ce=%b ad=%h, want all 0",
                     tvalid, tdata, tlast, row_mode, busy, done, cenb, addrb);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        mon_clear(); depth_exp = 0; depth = 8'd0;
        do_start();
        wait_done(200, 0, got);
        checks++;
        if (got !== 1'b1 || n_words !== 32 || n_bad !== 0 || n_tlast !== 1) begin
            errors++;
            $display("FAIL restart: done=%b words=%0d bad=%0d tlast=%0d, want 1 32 0 1",
                     got, n_words, n_bad, n_tlast);
        end
    endtask

    task automatic test_enable_freeze();
        bit got;
        int i;
        int frz_bad;
        mon_clear(); depth_exp = 0; mode_val = 4'h6; depth = 8'd0;
        do_start();
        for (i = 0; i < 100 && exp_idx != 5; i++) begin
            @(posedge clk); #1;
        end
        en = 1'b0;
        frz_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (tdata !== 32'd5 || tvalid !== 1'b1 || tlast !== 1'b0 || busy !== 1'b1)
                frz_bad++;
        end
        checks++;
        if (frz_bad !== 0 || exp_idx !== 5) begin
            errors++;
            $display("FAIL freeze: changed=%0d words=%0d tdata=%h, want 0 5 00000005",
                     frz_bad, exp_idx, tdata);
        end
        en = 1'b1;
        wait_done(200, 0, got);
        checks++;
        if (got !== 1'b1 || n_words !== 32 || n_bad !== 0 || n_tlast !== 1) begin
            errors++;
            $display("FAIL after_freeze: done=%b words=%0d bad=%0d tlast=%0d, want 1 32 0 1",
                     got, n_words, n_bad, n_tlast);
        end
    endtask

    task automatic test_full_depth();
        bit got;
        mon_clear(); depth_exp = 255; mode_val = 4'hA; depth = 8'd255;
        do_start();
        wait_done(12000, 0, got);
        checks++;
        if (got !== 1'b1 || n_words !== 8192 || n_tlast !== 1) begin
            errors++;
            $display("FAIL full_count: done=%b words=%0d tlast=%0d, want 1 8192 1",
                     got, n_words, n_tlast);
        end
        checks++;
        if (max_addr !== 8'd255 || n_bad !== 0) begin
            errors++;
            $display("FAIL full_data: maxaddr=%0d bad=%0d, want 255 0", max_addr, n_bad);
        end
        depth = 8'd0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; depth = 8'd0; start = 1'b0; tready = 1'b1;
        depth_exp = 0;
        mon_clear();
        test_reset();
        test_single_row();
        test_back_to_back_stall();
        test_start_ignored();
        test_reset_mid();
        test_enable_freeze();
        test_full_depth();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
